// File: rtl/obuf_pkg.sv
// obuf_pkg: shared types, constants and helpers for the output-buffer read side
package obuf_pkg;

    typedef enum logic [1:0] {ST_FILL, ST_DRAIN, ST_OUT} rd_state_t;

    localparam int OBUF_LANES = 4;

    // fill count 0..4 -> contiguous low-order byte enable mask
    function automatic logic [3:0] be_from_fill(input logic [2:0] fill);
        return 4'((5'd1 << fill) - 5'd1);
    endfunction

endpackage

// File: rtl/obuf_word_packer.sv
// obuf_word_packer: byte lane registers and fill counter for little-endian word assembly
module obuf_word_packer
    import obuf_pkg::*;
(
    input  logic                      r_clk,
    input  logic                      n_rst,
    input  logic                      cap,
    input  logic                      clr,
    input  logic [7:0]                rdata,
    output logic [2:0]                fill,
    output logic [8*OBUF_LANES-1:0]   lanes
);

    // capture the arriving byte into the next free lane; clear everything on hand-off
    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            fill  <= '0;
            lanes <= '0;
        end else if (clr) begin
            fill  <= '0;
            lanes <= '0;
        end else if (cap) begin
            lanes[{fill[1:0], 3'b000} +: 8] <= rdata;
            fill                            <= fill + 3'd1;
        end
    end

endmodule

// File: rtl/obuf_read_packer.sv
// obuf_read_packer: pops the output FIFO and emits packed 32-bit words on a valid/ready port
module obuf_read_packer
    import obuf_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 r_clk,
    input  logic                 n_rst,
    input  logic                 fifo_empty,
    input  logic [7:0]           fifo_rdata,
    output logic                 r_en,
    input  logic                 flush,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_be,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     words_sent
);

    rd_state_t                 state, state_n;
    logic                      inflight;
    logic                      flush_pend;
    logic                      last_q;
    logic                      accept;
    logic                      drop;
    logic [2:0]                fill;
    logic [8*OBUF_LANES-1:0]   lanes;

    obuf_word_packer u_pack (
        .r_clk (r_clk),
        .n_rst (n_rst),
        .cap   (inflight),
        .clr   (accept),
        .rdata (fifo_rdata),
        .fill  (fill),
        .lanes (lanes)
    );

    // state register
    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) state <= ST_FILL;
        else        state <= state_n;
    end

    // next state: a capture completing the word wins over a pending flush
    always_comb begin
        state_n = state;
        case (state)
            ST_FILL:  state_n = (inflight && fill == 3'd3) ? ST_OUT
                              : !flush_pend                ? ST_FILL
                              : inflight                   ? ST_DRAIN
                              : (fill != 3'd0)             ? ST_OUT
                              :                              ST_FILL;
            ST_DRAIN: state_n = inflight ? ST_DRAIN : ST_OUT;
            ST_OUT:   state_n = out_ready ? ST_FILL : ST_OUT;
            default:  state_n = ST_FILL;
        endcase
    end

    // outputs: pops only while filling, word fields gated to zero outside OUT
    always_comb begin
        r_en      = n_rst & (state == ST_FILL) & ~fifo_empty & ~flush_pend
                  & ((4'(fill) + 4'(inflight)) < 4'(LANES));
        out_valid = (state == ST_OUT);
        out_data  = out_valid ? lanes : '0;
        out_be    = out_valid ? be_from_fill(fill) : '0;
        out_last  = out_valid & last_q;
        accept    = out_valid & out_ready;
        drop      = (state == ST_FILL) & flush_pend & (fill == 3'd0) & ~inflight;
    end

    // in-flight tracking, flush bookkeeping, frozen last flag and accepted-word counter
    always_ff @(posedge r_clk or negedge n_rst) begin
        if (!n_rst) begin
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            last_q     <= 1'b0;
            words_sent <= '0;
        end else begin
            inflight   <= r_en;
            flush_pend <= flush | (flush_pend & ~(accept & last_q) & ~drop);
            if (state != ST_OUT && state_n == ST_OUT) last_q <= flush_pend;
            if (accept) words_sent <= words_sent + CNT_W'(1);
        end
    end

endmodule
